// File: rtl/mux_scan_ctrl_pkg.sv
// Shared calculator definitions: FSM state encodings and the default datapath width.
package mux_scan_ctrl_pkg;

    localparam int CALC_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/mux_scan_ctrl_step_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and flags the final count.
// Also used by the display refresh logic.
module step_timer #(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sweeps the bit-select mux through every input, collects one bit per index and
// offers the assembled word downstream. valid_out/ready_in: a word transfers on a
// clock edge where both are 1; valid_out never drops and word_out never changes before that.
module mux_scan_ctrl
    import mux_scan_ctrl_pkg::*;
#(
    parameter int NUM_INPUTS = CALC_WIDTH,
    parameter int DWELL      = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_in,
    input  logic                          mux_bit_in,
    input  logic                          ready_in,
    output logic [$clog2(NUM_INPUTS)-1:0] select_out,
    output logic                          busy_out,
    output logic [NUM_INPUTS-1:0]         word_out,
    output logic                          valid_out,
    output logic [1:0]                    state_out
);

    localparam int SW = $clog2(NUM_INPUTS);
    localparam logic [SW-1:0] SEL_LAST = SW'(NUM_INPUTS - 1);

    logic [1:0]            state_q, state_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [NUM_INPUTS-1:0] stage_q, stage_d;
    logic [NUM_INPUTS-1:0] word_q, word_d;
    logic                  valid_q, valid_d;
    logic                  dwell_last;

    // Timer is held at zero outside SCAN so every scan starts on a fresh dwell.
    step_timer #(.DWELL(DWELL)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != ST_SCAN),
        .en_i   (state_q == ST_SCAN),
        .last_o (dwell_last)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        stage_d = stage_q;
        word_d  = word_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                sel_d = '0;
                if (start_in) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (dwell_last) begin
                    stage_d[sel_q] = mux_bit_in;
                    if (sel_q == SEL_LAST) begin
                        word_d  = stage_d;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                sel_d = '0;
                if (ready_in) begin
                    valid_d = 1'b0;
                    state_d = start_in ? ST_SCAN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            stage_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            stage_q <= stage_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign select_out = sel_q;
    assign busy_out   = (state_q != ST_IDLE);
    assign word_out   = word_q;
    assign valid_out  = valid_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (8x1, 8x3, 2x1) each driving a modelled mux,
// directed scenarios followed by randomized scans with backpressure and chained starts.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   [3];
    logic       start [3];
    logic       ready [3];
    logic [7:0] data  [3];
    logic       mbit  [3];
    logic [2:0] sel   [3];
    logic       busy  [3];
    logic [7:0] word  [3];
    logic       valid [3];

    logic [2:0] s0, s1;
    logic [0:0] s2;
    logic [7:0] w0, w1;
    logic [1:0] w2;
    logic [1:0] st0, st1, st2;

    int nin [3] = '{8, 8, 2};
    int dwl [3] = '{1, 3, 1};
    logic [7:0] last_word [3];

    int checks   = 0;
    int failures = 0;

    assign sel[0]  = s0;
    assign sel[1]  = s1;
    assign sel[2]  = {2'b00, s2};
    assign word[0] = w0;
    assign word[1] = w1;
    assign word[2] = {6'b0, w2};
    assign mbit[0] = data[0][s0];
    assign mbit[1] = data[1][s1];
    assign mbit[2] = data[2][s2];

    mux_scan_ctrl #(.NUM_INPUTS(8), .DWELL(1)) u_dut0 (
        .clk(clk), .rst(rst[0]), .start_in(start[0]), .mux_bit_in(mbit[0]),
        .ready_in(ready[0]), .select_out(s0), .busy_out(busy[0]), .word_out(w0),
        .valid_out(valid[0]), .state_out(st0)
    );
    mux_scan_ctrl #(.NUM_INPUTS(8), .DWELL(3)) u_dut1 (
        .clk(clk), .rst(rst[1]), .start_in(start[1]), .mux_bit_in(mbit[1]),
        .ready_in(ready[1]), .select_out(s1), .busy_out(busy[1]), .word_out(w1),
        .valid_out(valid[1]), .state_out(st1)
    );
    mux_scan_ctrl #(.NUM_INPUTS(2), .DWELL(1)) u_dut2 (
        .clk(clk), .rst(rst[2]), .start_in(start[2]), .mux_bit_in(mbit[2]),
        .ready_in(ready[2]), .select_out(s2), .busy_out(busy[2]), .word_out(w2),
        .valid_out(valid[2]), .state_out(st2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int idx);
        check("idle_busy", 32'(busy[idx]), 0);
        check("idle_valid", 32'(valid[idx]), 0);
        check("idle_sel", 32'(sel[idx]), 0);
        check("idle_word", 32'(word[idx]), 32'(last_word[idx]));
    endtask

    task automatic accept(input int idx);
        check_idle(idx);
        start[idx] = 1'b1;
        ready[idx] = 1'b0;
        tick();
        start[idx] = 1'b0;
    endtask

    // Entered one cycle after the edge that accepted the scan. Expected word bit i is
    // whatever the mux presented for input i on the last dwell cycle of index i.
    task automatic run_scan(input int idx, input logic [7:0] d, input bit rnd,
                            input int hold, input bit chain);
        int n;
        int dw;
        logic [7:0] exp;
        n   = nin[idx];
        dw  = dwl[idx];
        exp = '0;
        data[idx] = d;
        for (int k = 0; k < n * dw; k++) begin
            if (rnd) data[idx] = 8'($urandom);
            start[idx] = 1'($urandom_range(0, 1));
            check("scan_sel", 32'(sel[idx]), 32'(k / dw));
            check("scan_valid", 32'(valid[idx]), 0);
            check("scan_busy", 32'(busy[idx]), 1);
            check("scan_word_held", 32'(word[idx]), 32'(last_word[idx]));
            if (k % dw == dw - 1) exp[k / dw] = data[idx][k / dw];
            tick();
        end
        exp = exp & 8'((1 << n) - 1);
        check("done_valid", 32'(valid[idx]), 1);
        check("done_word", 32'(word[idx]), 32'(exp));
        check("done_sel", 32'(sel[idx]), 0);
        last_word[idx] = exp;
        for (int h = 0; h < hold; h++) begin
            ready[idx] = 1'b0;
            start[idx] = 1'($urandom_range(0, 1));
            tick();
            check("hold_valid", 32'(valid[idx]), 1);
            check("hold_word", 32'(word[idx]), 32'(exp));
            check("hold_busy", 32'(busy[idx]), 1);
            check("hold_sel", 32'(sel[idx]), 0);
        end
        ready[idx] = 1'b1;
        start[idx] = chain;
        tick();
        ready[idx] = 1'b0;
        start[idx] = 1'b0;
        check("hs_valid", 32'(valid[idx]), 0);
        check("hs_busy", 32'(busy[idx]), 32'(chain));
        check("hs_word", 32'(word[idx]), 32'(exp));
        check("hs_sel", 32'(sel[idx]), 0);
    endtask

    initial begin
        bit chained;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; start[i] = 1'b1; ready[i] = 1'b1; data[i] = 8'hFF;
            last_word[i] = '0;
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            check("rst_busy", 32'(busy[i]), 0);
            check("rst_valid", 32'(valid[i]), 0);
            check("rst_sel", 32'(sel[i]), 0);
            check("rst_word", 32'(word[i]), 0);
            rst[i] = 1'b0; start[i] = 1'b0; ready[i] = 1'b0;
        end

        // Directed: stable data, backpressure with start pulses, then release to IDLE.
        accept(0); run_scan(0, 8'hA5, 0, 5, 0);
        accept(1); run_scan(1, 8'h3C, 0, 2, 0);
        accept(2); run_scan(2, 8'h02, 0, 1, 0);

        // Back-to-back: handshake with start held, new data for the next scan.
        accept(0); run_scan(0, 8'hA5, 0, 1, 1);
        run_scan(0, 8'h0F, 0, 0, 0);

        // Reset in the middle of a scan.
        data[0] = 8'h5A;
        accept(0);
        tick(); tick(); tick();
        check("mid_sel", 32'(sel[0]), 3);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("midrst_busy", 32'(busy[0]), 0);
        check("midrst_valid", 32'(valid[0]), 0);
        check("midrst_sel", 32'(sel[0]), 0);
        check("midrst_word", 32'(word[0]), 0);
        last_word[0] = '0;
        accept(0); run_scan(0, 8'hC3, 0, 0, 0);

        // Randomized scans: data may change every cycle, random hold and chaining.
        for (int idx = 0; idx < 3; idx++) begin
            chained = 1'b0;
            for (int it = 0; it < 20; it++) begin
                bit ch;
                ch = 1'($urandom_range(0, 1));
                if (!chained) accept(idx);
                run_scan(idx, 8'($urandom), 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 4)), ch);
                chained = ch;
            end
            if (chained) run_scan(idx, 8'($urandom), 1'b0, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
